gates_checker: RTL and testbench
================================

// Module: gates_checker
// PURPOSE
//  Self-test driver/checker for the two-input logic gates block. It drives the a/b inputs
//  through all four input vectors and samples the six gate outputs (and, or, not, xor,
//  nand, nor) after a settle interval. Results are compared against a truth-table model,
//  and a per-gate fail mask plus a pass flag are reported.
//  Sits beside the gates block on the XC7S50 board top, between the button/LED glue and the gates block.
// PARAMETERS
//  SETTLE_CYCLES  4  clocks each vector is held before sampling; legal range >= 1
// PORTS
//  clk             in   1  system clock; single clock domain
//  rst             in   1  synchronous, active-high reset
//  start           in   1  level; sampled only in IDLE
//  drive_a         out  1  registered a stimulus to the gates block
//  drive_b         out  1  registered b stimulus to the gates block
//  and_in          in   1  gates block and output
//  or_in           in   1  gates block or output
//  not_in          in   1  gates block not output
//  xor_in          in   1  gates block xor output
//  nand_in         in   1  gates block nand output
//  nor_in          in   1  gates block nor output
//  busy            out  1  high in every state other than IDLE
//  done            out  1  one-cycle pulse when a run completes
//  pass            out  1  1 when the last run had no mismatches; held until the next start
//  fail_mask       out  6  sticky mismatch per gate: [5]and [4]or [3]not [2]xor [1]nand [0]nor
//  first_fail_vec  out  2  {a,b} of the first failing vector; valid only when pass=0 after done
// BEHAVIOUR
//  Reset values: drive_a, drive_b, busy, done, pass, fail_mask and first_fail_vec are all 0.
//  Reset state is IDLE.
//  Reset mid-run: reset wins. All outputs return to reset values on the next edge, and no done pulse is issued.
//  Vector encoding: vec[1:0] with drive_a=vec[1], drive_b=vec[0]. Vectors run in the order 0,1,2,3.
//  FSM states and transitions:
//   IDLE: if start=1, then vec<=0, fail_mask<=0, first_fail_vec<=0, pass<=0,
//     cnt<=SETTLE_CYCLES-1, and the FSM goes to SETTLE.
//     drive_a/drive_b take the new vec on the same edge.
//   SETTLE: cnt decrements by 1 each cycle. When cnt==0, go to SAMPLE.
//   SAMPLE: compare the six inputs with expected(vec) and OR the mismatch bits into fail_mask.
//     If the current mismatch is nonzero, fail_mask (pre-update) is 0 and this is the first
//     failure, then first_fail_vec<=vec.
//     If vec==3, go to DONE. Otherwise vec<=vec+1, cnt<=SETTLE_CYCLES-1, and go to SETTLE.
//   DONE: done=1 for this single cycle and pass<=(fail_mask==0), then go to IDLE.
//  Expected values: and=a&b, or=a|b, not=~a, xor=a^b, nand=~(a&b), nor=~(a|b).
//  Timing: the start edge is cycle 0.
//   Vector k is sampled at cycle (k+1)*(SETTLE_CYCLES+1).
//   done is high in cycle 4*(SETTLE_CYCLES+1)+1, which is 21 at the default.
//  start while busy=1: ignored, with no effect on the run in progress.
//  start held high: a new run begins on the first IDLE cycle after DONE, so back-to-back runs are legal.
//  Inputs are sampled directly and are not synchronised. The gates block is combinational from drive_a/drive_b on the same clk.
//  vec wraps only through IDLE. The 2-bit increment never executes at vec==3.
// STRUCTURE
//  Package gates_chk_pkg holds:
//   the state enum (IDLE, SETTLE, SAMPLE, DONE);
//   the fail_mask bit-index constants (AND_B=5 ... NOR_B=0);
//   the function expected_gates(a,b), returning a 6-bit value.
//  Sub-module gates_ref_model: combinational truth-table model, maps vec[1:0] to exp[5:0], and is shared with the bench scoreboard.
//  The counter and the FSM stay in gates_checker.
// TESTING
//  1. Healthy gates block, SETTLE_CYCLES=4, start pulsed at cycle 0 -> done at cycle 21, pass=1, fail_mask=6'b000000.
//  2. xor output stuck at 0 -> fail_mask=6'b000100, first_fail_vec=2'b01, pass=0.
//  3. nand and nor outputs swapped -> fail_mask=6'b000011, first_fail_vec=2'b01, pass=0.
//  4. start re-pulsed at cycles 5 and 12 during a run -> single done at cycle 21; drive sequence is 00,01,10,11 only.
//  5. rst asserted at cycle 10 -> cycle 11 has busy=0 and drive_a=drive_b=0, and done never pulses; a new start then completes normally.
//  6. SETTLE_CYCLES=1 with start held high -> done at cycles 9 and 19; pass reads 0 between each restart and the next DONE.

Source files
------------

// File: rtl/gates_chk_pkg.sv
// Shared definitions for the gates self-test checker: FSM states, fail_mask bit
// positions and the two-input gate truth function.
package gates_chk_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_e;

    localparam int GATE_W = 6;
    localparam int VEC_W  = 2;

    localparam int AND_B  = 5;
    localparam int OR_B   = 4;
    localparam int NOT_B  = 3;
    localparam int XOR_B  = 2;
    localparam int NAND_B = 1;
    localparam int NOR_B  = 0;

    localparam logic [VEC_W-1:0] LAST_VEC = 2'd3;

    function automatic logic [GATE_W-1:0] expected_gates(input logic a, input logic b);
        logic [GATE_W-1:0] res;
        res         = '0;
        res[AND_B]  = a & b;
        res[OR_B]   = a | b;
        res[NOT_B]  = ~a;
        res[XOR_B]  = a ^ b;
        res[NAND_B] = ~(a & b);
        res[NOR_B]  = ~(a | b);
        return res;
    endfunction

endpackage

// File: rtl/gates_ref_model.sv
// Combinational truth-table model: maps a {a,b} vector to the six expected gate outputs.
module gates_ref_model
    import gates_chk_pkg::*;
(
    input  logic [VEC_W-1:0]  vec_i,
    output logic [GATE_W-1:0] exp_o
);

    logic [GATE_W-1:0] table_w [4];

    // One constant row per input vector; the lookup below is a 4-entry mux.
    for (genvar gi = 0; gi < 4; gi++) begin : g_row
        localparam logic [VEC_W-1:0] ROW_VEC = gi[VEC_W-1:0];
        assign table_w[gi] = expected_gates(ROW_VEC[1], ROW_VEC[0]);
    end

    assign exp_o = table_w[vec_i];

endmodule

// File: rtl/gates_checker.sv
// Self-test driver/checker for the two-input gates block: steps a/b through all four
// vectors, samples the six gate outputs after a settle interval and reports mismatches.
module gates_checker
    import gates_chk_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              drive_a,
    output logic              drive_b,
    input  logic              and_in,
    input  logic              or_in,
    input  logic              not_in,
    input  logic              xor_in,
    input  logic              nand_in,
    input  logic              nor_in,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [GATE_W-1:0] fail_mask,
    output logic [VEC_W-1:0]  first_fail_vec
);

    // A width of at least one bit keeps SETTLE_CYCLES=1 legal.
    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(SETTLE_CYCLES - 1);

    state_e             state_q, state_d;
    logic [VEC_W-1:0]   vec_q, vec_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [GATE_W-1:0]  fail_q, fail_d;
    logic [VEC_W-1:0]   ffv_q, ffv_d;
    logic               pass_q, pass_d;

    logic [GATE_W-1:0]  exp_w;
    logic [GATE_W-1:0]  obs_w;
    logic [GATE_W-1:0]  mism_w;

    gates_ref_model u_ref (
        .vec_i (vec_q),
        .exp_o (exp_w)
    );

    always_comb begin
        obs_w         = '0;
        obs_w[AND_B]  = and_in;
        obs_w[OR_B]   = or_in;
        obs_w[NOT_B]  = not_in;
        obs_w[XOR_B]  = xor_in;
        obs_w[NAND_B] = nand_in;
        obs_w[NOR_B]  = nor_in;
    end

    assign mism_w = obs_w ^ exp_w;

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SETTLE;
            SETTLE:  if (cnt_q == '0) state_d = SAMPLE;
            SAMPLE:  state_d = (vec_q == LAST_VEC) ? DONE : SETTLE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy = (state_q != IDLE);
        done = (state_q == DONE);
    end

    // Datapath next-state: vector, settle counter and result registers.
    always_comb begin
        vec_d  = vec_q;
        cnt_d  = cnt_q;
        fail_d = fail_q;
        ffv_d  = ffv_q;
        pass_d = pass_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    vec_d  = '0;
                    fail_d = '0;
                    ffv_d  = '0;
                    pass_d = 1'b0;
                    cnt_d  = CNT_RELOAD;
                end
            end
            SETTLE: begin
                if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
            end
            SAMPLE: begin
                fail_d = fail_q | mism_w;
                if ((mism_w != '0) && (fail_q == '0)) ffv_d = vec_q;
                // The increment is skipped at the last vector; wrap happens only via IDLE.
                if (vec_q != LAST_VEC) begin
                    vec_d = vec_q + 2'd1;
                    cnt_d = CNT_RELOAD;
                end
            end
            DONE: begin
                pass_d = (fail_q == '0);
            end
            default: begin
                vec_d = vec_q;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vec_q  <= '0;
            cnt_q  <= '0;
            fail_q <= '0;
            ffv_q  <= '0;
            pass_q <= 1'b0;
        end else begin
            vec_q  <= vec_d;
            cnt_q  <= cnt_d;
            fail_q <= fail_d;
            ffv_q  <= ffv_d;
            pass_q <= pass_d;
        end
    end

    assign drive_a        = vec_q[1];
    assign drive_b        = vec_q[0];
    assign pass           = pass_q;
    assign fail_mask      = fail_q;
    assign first_fail_vec = ffv_q;

endmodule

// File: tb/tb_gates_checker.sv
// Scoreboard bench for gates_checker: two instances (settle 4 and settle 1) driven by a
// behavioural gates block whose per-vector outputs can be corrupted on purpose.
module tb_gates_checker;

    typedef struct {
        int unsigned done_cyc;
        logic        pass;
        logic [5:0]  fmask;
        logic [1:0]  ffv;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       rst_s   [2];
    logic       start_s [2];
    logic       da_s    [2];
    logic       db_s    [2];
    logic       busy_s  [2];
    logic       done_s  [2];
    logic       pass_s  [2];
    logic [5:0] fm_s    [2];
    logic [1:0] ffv_s   [2];
    logic [5:0] gin_s   [2];
    logic [5:0] gate_tbl [2][4];

    exp_t sb_q [2][$];

    int errors = 0;
    int checks = 0;

    function automatic int settle_of(input int g);
        return (g == 0) ? 4 : 1;
    endfunction

    // Gate truth straight from the Boolean definitions, ordered and,or,not,xor,nand,nor.
    function automatic logic [5:0] truth(input logic [1:0] v);
        logic a, b;
        a = v[1];
        b = v[0];
        return {a & b, a | b, ~a, a ^ b, ~(a & b), ~(a | b)};
    endfunction

    task automatic check(input string name, input int g, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s dut%0d cyc=%0d: got %0h, want %0h", name, g, cyc, act, req);
        end
    endtask

    function automatic exp_t make_exp(input int g, input int unsigned done_cyc);
        exp_t e;
        logic [5:0] m;
        e.done_cyc = done_cyc;
        e.fmask    = '0;
        e.ffv      = '0;
        for (int v = 0; v < 4; v++) begin
            m = gate_tbl[g][v] ^ truth(2'(v));
            if (m != 0 && e.fmask == 0) e.ffv = 2'(v);
            e.fmask |= m;
        end
        e.pass = (e.fmask == 0);
        return e;
    endfunction

    task automatic set_healthy(input int g);
        for (int v = 0; v < 4; v++) gate_tbl[g][v] = truth(2'(v));
    endtask

    // Called at a negedge; that negedge's following posedge is cycle 0 of the run.
    task automatic start_run(input int g, input int hold, input bit expect_done);
        int unsigned n;
        n = cyc;
        if (expect_done) sb_q[g].push_back(make_exp(g, n + 4 * (settle_of(g) + 1) + 1));
        start_s[g] = 1'b1;
        repeat (hold) @(negedge clk);
        start_s[g] = 1'b0;
    endtask

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        localparam int S = (gi == 0) ? 4 : 1;

        assign gin_s[gi] = gate_tbl[gi][{da_s[gi], db_s[gi]}];

        gates_checker #(.SETTLE_CYCLES(S)) u_dut (
            .clk            (clk),
            .rst            (rst_s[gi]),
            .start          (start_s[gi]),
            .drive_a        (da_s[gi]),
            .drive_b        (db_s[gi]),
            .and_in         (gin_s[gi][5]),
            .or_in          (gin_s[gi][4]),
            .not_in         (gin_s[gi][3]),
            .xor_in         (gin_s[gi][2]),
            .nand_in        (gin_s[gi][1]),
            .nor_in         (gin_s[gi][0]),
            .busy           (busy_s[gi]),
            .done           (done_s[gi]),
            .pass           (pass_s[gi]),
            .fail_mask      (fm_s[gi]),
            .first_fail_vec (ffv_s[gi])
        );

        // Monitor: pops an expectation on every done pulse, checks pass one cycle later.
        initial begin : mon
            logic [1:0] seen [$];
            logic       pend;
            logic       pend_pass;
            logic [7:0] seq;
            exp_t       e;
            pend = 1'b0;
            pend_pass = 1'b0;
            forever begin
                @(negedge clk);
                if (pend) begin
                    check("pass_after_done", gi, 32'(pass_s[gi]), 32'(pend_pass));
                    check("done_one_cycle", gi, 32'(done_s[gi]), 32'(0));
                    pend = 1'b0;
                end
                if (rst_s[gi] === 1'b1 || busy_s[gi] !== 1'b1) begin
                    seen.delete();
                end else if (seen.size() == 0 || seen[$] !== {da_s[gi], db_s[gi]}) begin
                    seen.push_back({da_s[gi], db_s[gi]});
                end
                if (done_s[gi] === 1'b1) begin
                    if (sb_q[gi].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done dut%0d cyc=%0d: got done=1, want none", gi, cyc);
                    end else begin
                        e = sb_q[gi].pop_front();
                        check("done_cycle", gi, 32'(cyc), 32'(e.done_cyc));
                        check("fail_mask", gi, 32'(fm_s[gi]), 32'(e.fmask));
                        if (!e.pass) check("first_fail_vec", gi, 32'(ffv_s[gi]), 32'(e.ffv));
                        check("drive_count", gi, 32'(seen.size()), 32'(4));
                        if (seen.size() == 4) begin
                            seq = {seen[0], seen[1], seen[2], seen[3]};
                            check("drive_seq", gi, 32'(seq), 32'h1b);
                        end
                        pend = 1'b1;
                        pend_pass = e.pass;
                    end
                end
            end
        end
    end

    initial begin
        int unsigned n;
        for (int g = 0; g < 2; g++) begin
            rst_s[g]   = 1'b1;
            start_s[g] = 1'b0;
            set_healthy(g);
        end
        repeat (3) @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            check("rst_busy", g, 32'(busy_s[g]), 32'(0));
            check("rst_done", g, 32'(done_s[g]), 32'(0));
            check("rst_pass", g, 32'(pass_s[g]), 32'(0));
            check("rst_fail_mask", g, 32'(fm_s[g]), 32'(0));
            check("rst_ffv", g, 32'(ffv_s[g]), 32'(0));
            check("rst_drive", g, 32'({da_s[g], db_s[g]}), 32'(0));
            rst_s[g] = 1'b0;
        end
        @(negedge clk);

        // Healthy block.
        start_run(0, 1, 1'b1);
        repeat (26) @(negedge clk);

        // xor output stuck at 0.
        set_healthy(0);
        for (int v = 0; v < 4; v++) gate_tbl[0][v][2] = 1'b0;
        start_run(0, 1, 1'b1);
        repeat (26) @(negedge clk);

        // nand and nor outputs swapped.
        set_healthy(0);
        for (int v = 0; v < 4; v++) begin
            gate_tbl[0][v][1] = truth(2'(v)) >> 0;
            gate_tbl[0][v][0] = truth(2'(v)) >> 1;
        end
        start_run(0, 1, 1'b1);
        repeat (26) @(negedge clk);

        // start re-pulsed mid-run at cycles 5 and 12 must be ignored.
        set_healthy(0);
        start_run(0, 1, 1'b1);
        repeat (4) @(negedge clk);
        start_s[0] = 1'b1;
        @(negedge clk);
        start_s[0] = 1'b0;
        repeat (6) @(negedge clk);
        start_s[0] = 1'b1;
        @(negedge clk);
        start_s[0] = 1'b0;
        repeat (20) @(negedge clk);

        // Reset at cycle 10 aborts the run without a done pulse.
        n = cyc;
        start_run(0, 1, 1'b0);
        while (cyc != n + 10) @(negedge clk);
        rst_s[0] = 1'b1;
        @(negedge clk);
        check("midrst_busy", 0, 32'(busy_s[0]), 32'(0));
        check("midrst_drive", 0, 32'({da_s[0], db_s[0]}), 32'(0));
        check("midrst_fail_mask", 0, 32'(fm_s[0]), 32'(0));
        rst_s[0] = 1'b0;
        repeat (25) @(negedge clk);
        start_run(0, 1, 1'b1);
        repeat (26) @(negedge clk);

        // Settle of one with start held: back-to-back runs done at cycles 9 and 19.
        n = cyc;
        sb_q[1].push_back(make_exp(1, n + 9));
        sb_q[1].push_back(make_exp(1, n + 19));
        start_s[1] = 1'b1;
        while (cyc != n + 11) @(negedge clk);
        for (int k = 11; k <= 18; k++) begin
            check("pass_cleared_on_restart", 1, 32'(pass_s[1]), 32'(0));
            @(negedge clk);
        end
        start_s[1] = 1'b0;
        repeat (6) @(negedge clk);

        // Random corruptions of the gate outputs per vector.
        for (int r = 0; r < 24; r++) begin
            for (int v = 0; v < 4; v++) begin
                gate_tbl[0][v] = truth(2'(v));
                if ($urandom_range(0, 1) == 1) gate_tbl[0][v] ^= 6'($urandom) & 6'($urandom);
            end
            start_run(0, $urandom_range(1, 4), 1'b1);
            repeat (24 + $urandom_range(0, 3)) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        for (int g = 0; g < 2; g++) check("runs_outstanding", g, 32'(sb_q[g].size()), 32'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
